dma_priority: RTL and testbench

//  Priority/request logic of the 8237A-style DMA controller. Synchronises the four DREQ lines and applies mask,

---
 rtl/dma_pkg.sv | 16 +
 rtl/dma_pri_arbiter.sv | 28 ++
 rtl/dma_priority.sv | 91 +++++++++
 tb/tb_dma_priority.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and command-register bit positions for the DMA priority block
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } dma_state_e;

  localparam int CMD_DISABLE_BIT   = 2;
  localparam int CMD_ROT_PRI_BIT   = 4;
  localparam int CMD_DREQ_LOW_BIT  = 6;
  localparam int CMD_DACK_HIGH_BIT = 7;

endpackage

// File: rtl/dma_pri_arbiter.sv
// rtl/dma_pri_arbiter.sv - combinational 4-way fixed/rotating priority arbiter
module dma_pri_arbiter (
  input  logic [3:0] pending,
  input  logic [1:0] ptr,
  input  logic       rot,
  output logic [1:0] grant,
  output logic       grant_valid
);

  logic [1:0] base;
  logic [1:0] idx;

  // Walk offsets from the far end so the nearest pending channel to base wins last.
  always_comb begin
    grant       = 2'd0;
    grant_valid = 1'b0;
    base        = rot ? ptr : 2'd0;
    idx         = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = base + 2'(i);
      if (pending[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_priority.sv
// rtl/dma_priority.sv - DREQ synchronisation, HRQ/HLDA handshake FSM and DACK grant for the DMA controller
module dma_priority
  import dma_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] DREQ,
  input  logic       HLDA,
  input  logic [3:0] mask,
  input  logic [3:0] sw_req,
  input  logic       cmd_disable,
  input  logic       cmd_rot_pri,
  input  logic       cmd_dreq_low,
  input  logic       cmd_dack_high,
  input  logic       xfer_done,
  output logic       HRQ,
  output logic [3:0] DACK,
  output logic [1:0] active_ch,
  output logic       ch_valid
);

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]                  req_hw;
  logic [3:0]                  pending;
  logic [1:0]                  grant;
  logic                        grant_valid;
  logic [1:0]                  ptr_q;
  logic [1:0]                  active_ch_q;
  logic [3:0]                  dack_act;
  logic                        svc_end;
  dma_state_e                  state_q;
  dma_state_e                  state_d;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], DREQ};
  end

  assign req_hw  = sync_q[SYNC_STAGES-1] ^ {4{cmd_dreq_low}};
  assign pending = (req_hw & ~mask) | sw_req;

  dma_pri_arbiter u_arb (
    .pending     (pending),
    .ptr         (ptr_q),
    .rot         (cmd_rot_pri),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Losing HLDA mid-service ends the service exactly like xfer_done.
  assign svc_end = xfer_done || !HLDA;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|pending && !cmd_disable && !HLDA) state_d = REQ;
      REQ:     if (HLDA && grant_valid)               state_d = ACTIVE;
               else if (!grant_valid)                 state_d = RELEASE;
      ACTIVE:  if (svc_end)                           state_d = RELEASE;
      RELEASE: if (!HLDA)                             state_d = IDLE;
      default:                                        state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      active_ch_q <= 2'd0;
      ptr_q       <= 2'd0;
    end else begin
      if (state_q == REQ && HLDA && grant_valid) active_ch_q <= grant;
      // Completed channel drops to lowest priority in rotating mode.
      if (state_q == ACTIVE && svc_end && cmd_rot_pri) ptr_q <= active_ch_q + 2'd1;
    end
  end

  always_comb begin
    HRQ       = (state_q == REQ) || (state_q == ACTIVE);
    ch_valid  = (state_q == ACTIVE);
    active_ch = active_ch_q;
    dack_act  = ch_valid ? (4'b0001 << active_ch_q) : 4'b0000;
    DACK      = cmd_dack_high ? dack_act : ~dack_act;
  end

endmodule

// File: tb/tb_dma_priority.sv
// tb/tb_dma_priority.sv - directed and randomized self-checking bench for dma_priority
module tb_dma_priority;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] DREQ;
  logic       HLDA;
  logic [3:0] mask;
  logic [3:0] sw_req;
  logic       cmd_disable;
  logic       cmd_rot_pri;
  logic       cmd_dreq_low;
  logic       cmd_dack_high;
  logic       xfer_done;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] active_ch;
  logic       ch_valid;

  int checks   = 0;
  int failures = 0;

  int         mptr;
  int         win;
  logic [3:0] mpend;
  logic       exp_hrq;
  logic       hrq_seen;
  logic       abort_svc;

  dma_priority #(.SYNC_STAGES(2)) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .DREQ          (DREQ),
    .HLDA          (HLDA),
    .mask          (mask),
    .sw_req        (sw_req),
    .cmd_disable   (cmd_disable),
    .cmd_rot_pri   (cmd_rot_pri),
    .cmd_dreq_low  (cmd_dreq_low),
    .cmd_dack_high (cmd_dack_high),
    .xfer_done     (xfer_done),
    .HRQ           (HRQ),
    .DACK          (DACK),
    .active_ch     (active_ch),
    .ch_valid      (ch_valid)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: first pending channel when searching upward from start, mod 4.
  function automatic int model_winner(input logic [3:0] p, input logic rot, input int ptr);
    int start;
    start = rot ? ptr : 0;
    for (int k = 0; k < 4; k++) begin
      if (p[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_dack(input int ch, input logic high, input logic act);
    logic [3:0] bits;
    bits = 4'b0000;
    if (act) bits[ch] = 1'b1;
    return high ? bits : ~bits;
  endfunction

  task automatic finish_svc();
    DREQ   = 4'b0000;
    sw_req = 4'b0000;
    repeat (3) tick();
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    HLDA = 1'b0;
    repeat (3) tick();
  endtask

  task automatic serve_next(input string tag, input int exp_ch);
    HLDA = 1'b1;
    tick();
    chk(tag, active_ch, exp_ch);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    HLDA = 1'b0;
    tick();
    tick();
  endtask

  task automatic reset_pulse();
    @(negedge CLK);
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  initial begin
    RESET_N = 1'b0; DREQ = 4'hF; HLDA = 1'b0; mask = 4'h0; sw_req = 4'h0;
    cmd_disable = 1'b0; cmd_rot_pri = 1'b0; cmd_dreq_low = 1'b0; cmd_dack_high = 1'b0;
    xfer_done = 1'b0;

    // Reset state and first-grant latency
    repeat (2) tick();
    chk("rst_hrq", HRQ, 1'b0);
    chk("rst_dack", DACK, 4'hF);
    chk("rst_valid", ch_valid, 1'b0);
    chk("rst_ch", active_ch, 2'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    DREQ    = 4'b0100;
    tick(); tick();
    chk("lat_edge2", HRQ, 1'b0);
    tick();
    chk("lat_edge3", HRQ, 1'b1);
    HLDA = 1'b1;
    tick();
    chk("grant_dack", DACK, 4'b1011);
    chk("grant_ch", active_ch, 2'd2);
    chk("grant_valid", ch_valid, 1'b1);
    DREQ = 4'b0000;
    repeat (3) tick();
    chk("active_hold", DACK, 4'b1011);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    chk("done_dack", DACK, 4'hF);
    chk("done_hrq", HRQ, 1'b0);
    HLDA = 1'b0;
    repeat (3) tick();

    // Fixed priority
    DREQ = 4'b1010;
    repeat (3) tick();
    chk("fix_hrq", HRQ, 1'b1);
    HLDA = 1'b1;
    tick();
    chk("fix_ch1", active_ch, 2'd1);
    DREQ = 4'b1000;
    repeat (3) tick();
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    HLDA = 1'b0;
    tick(); tick();
    chk("fix_rereq", HRQ, 1'b1);
    HLDA = 1'b1;
    tick();
    chk("fix_ch3", active_ch, 2'd3);
    finish_svc();

    // Rotating priority
    cmd_rot_pri = 1'b1;
    DREQ = 4'b0011;
    repeat (3) tick();
    serve_next("rot_g0", 0);
    chk("rot_rereq", HRQ, 1'b1);
    serve_next("rot_g1", 1);
    HLDA = 1'b1;
    tick();
    chk("rot_wrap", active_ch, 2'd0);
    finish_svc();
    cmd_rot_pri = 1'b0;

    // Mask and polarity
    mask = 4'hF;
    cmd_dreq_low = 1'b1;
    DREQ = 4'b1110;
    repeat (3) tick();
    mask = 4'b0001;
    repeat (5) tick();
    chk("mask_nohrq", HRQ, 1'b0);
    sw_req = 4'b0100;
    tick();
    chk("sw_hrq", HRQ, 1'b1);
    cmd_dack_high = 1'b1;
    HLDA = 1'b1;
    tick();
    chk("pol_dack", DACK, 4'b0100);
    chk("pol_ch", active_ch, 2'd2);
    mask = 4'hF;
    finish_svc();
    cmd_dreq_low = 1'b0;
    cmd_dack_high = 1'b0;
    repeat (3) tick();
    mask = 4'h0;

    // Withdraw before HLDA
    DREQ = 4'b0010;
    repeat (3) tick();
    chk("wd_hrq", HRQ, 1'b1);
    DREQ = 4'b0000;
    repeat (3) tick();
    chk("wd_drop", HRQ, 1'b0);
    chk("wd_dack", DACK, 4'hF);
    repeat (2) tick();

    // Asynchronous abort while ACTIVE
    DREQ = 4'b1000;
    repeat (3) tick();
    HLDA = 1'b1;
    tick();
    chk("abort_pre", ch_valid, 1'b1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("abort_hrq", HRQ, 1'b0);
    chk("abort_dack", DACK, 4'hF);
    chk("abort_valid", ch_valid, 1'b0);
    HLDA = 1'b0;
    DREQ = 4'b0000;
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (3) tick();

    // Disable
    cmd_disable = 1'b1;
    DREQ = 4'b0001;
    repeat (20) begin
      tick();
      chk("dis_hold", HRQ, 1'b0);
    end
    cmd_disable = 1'b0;
    hrq_seen = 1'b0;
    repeat (3) begin
      tick();
      if (HRQ) hrq_seen = 1'b1;
    end
    chk("dis_clear", hrq_seen, 1'b1);
    HLDA = 1'b1;
    tick();
    finish_svc();

    // Randomized services against the reference model
    reset_pulse();
    mptr = 0;
    for (int it = 0; it < 40; it++) begin
      mask          = 4'hF;
      sw_req        = 4'h0;
      DREQ          = 4'($urandom);
      cmd_dreq_low  = 1'($urandom);
      cmd_rot_pri   = 1'($urandom);
      cmd_dack_high = 1'($urandom);
      cmd_disable   = ($urandom_range(0, 7) == 0);
      repeat (3) tick();
      mask   = 4'($urandom);
      sw_req = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      tick(); tick();
      mpend   = ((DREQ ^ {4{cmd_dreq_low}}) & ~mask) | sw_req;
      exp_hrq = (mpend != 4'h0) && !cmd_disable;
      chk("rnd_hrq", HRQ, exp_hrq);
      if (exp_hrq) begin
        win = model_winner(mpend, cmd_rot_pri, mptr);
        HLDA = 1'b1;
        tick();
        chk("rnd_ch", active_ch, win);
        chk("rnd_dack", DACK, model_dack(win, cmd_dack_high, 1'b1));
        mask   = 4'hF;
        sw_req = 4'h0;
        abort_svc = 1'($urandom);
        if (abort_svc) begin
          HLDA = 1'b0;
          tick();
        end else begin
          xfer_done = 1'b1;
          tick();
          xfer_done = 1'b0;
          HLDA = 1'b0;
        end
        chk("rnd_end_hrq", HRQ, 1'b0);
        chk("rnd_end_dack", DACK, model_dack(0, cmd_dack_high, 1'b0));
        if (cmd_rot_pri) mptr = (win + 1) % 4;
        repeat (2) tick();
      end
      cmd_disable = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
